udp_traffic_gen: RTL and testbench
==================================

# udp_traffic_gen

Parametrised UDP payload traffic generator that drives the send-side user interface of `UDP_Stack_TOP`: `i_send_udp_data`, `i_send_udp_len`, `i_send_udp_last`, `i_send_udp_valid` and `o_send_ready`. It replaces the hard-wired 100-byte counter generator in the board top level. Frame length, inter-frame gap, packet count and payload pattern are configurable at run time. The block also supports auto-start after reset, graceful stop, and status counters for ILA and bring-up.

## Interface
**Parameters**
- P_MAX_LEN, 1472: maximum payload bytes; `i_len` is clamped to [1, P_MAX_LEN].
- P_AUTO_START, 1: 1 = start automatically P_START_DELAY cycles after reset release.
- P_START_DELAY, 100: post-reset delay in cycles before auto-start.
- P_PRBS_SEED, 8'hFF: LFSR seed, reloaded at the start of every frame. Must be non-zero.
- P_CONST_BYTE, 8'hA5: payload byte used in constant mode.

**Ports**

Clocking and reset (already decided):
- w_user_clk  in  1  clock.
- w_user_rst  in  1  reset: asynchronous, active-high.

Control and configuration:
- i_start  in  1  single-cycle start pulse; ignored unless in IDLE.
- i_stop  in  1  single-cycle graceful stop request.
- i_mode  in  2  payload pattern: 0 incrementing, 1 PRBS-8, 2 constant, 3 sequence-tagged.
- i_len  in  16  payload length in bytes.
- i_gap  in  16  extra idle cycles between frames.
- i_pkt_num  in  32  number of frames to send; 0 = unlimited.

UDP stack handshake:
- i_send_ready  in  1  connected to the stack's `o_send_ready`.
- o_send_udp_data  out  8  payload byte.
- o_send_udp_len  out  16  payload length of the current frame.
- o_send_udp_last  out  1  marks the final byte of the frame.
- o_send_udp_valid  out  1  payload byte valid.

Status:
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse when a run ends.
- o_pkt_cnt  out  32  frames completed in the current run.

## Operation
**States:** IDLE, WAIT_RDY, SEND, GAP, DONE.

**IDLE**
- A start trigger moves the FSM to WAIT_RDY. A trigger is either:
  - `i_start`, or
  - the one-time auto-start event when `r_start_cnt` reaches P_START_DELAY, with P_AUTO_START = 1.
- On the trigger the block latches `i_mode`, `i_gap`, `i_pkt_num` and the clamped `i_len`, and clears `o_pkt_cnt` and the stop flag.

**WAIT_RDY**
- If the stop flag is set, go to DONE.
- Else if `i_send_ready` = 1, go to SEND with byte index 0 and reload the LFSR with the seed.

**SEND**
- `o_send_udp_valid` is held high for exactly len consecutive cycles. The stack does not apply backpressure once a frame has started.
- `o_send_udp_last` is high only on byte index len-1. For len = 1, last and valid assert together.
- Payload byte per mode:
  - Mode 0: the byte index, low 8 bits; wraps 255 → 0.
  - Mode 1: LFSR output. The polynomial is x^8+x^6+x^5+x^4+1, Fibonacci form, shifted left. Byte 0 equals the seed, and the register advances once per byte.
  - Mode 2: P_CONST_BYTE.
  - Mode 3: bytes 0–1 carry `o_pkt_cnt[15:0]` big-endian; byte k ≥ 2 carries k[7:0]. For len = 1, only the MSB byte is sent.
- After the last byte, `o_pkt_cnt` increments (32-bit, wrapping). Then:
  - If the stop flag is set, or `i_pkt_num` ≠ 0 and the new count equals `i_pkt_num`, go to DONE.
  - Else if gap ≠ 0, go to GAP.
  - Else go to WAIT_RDY.

**GAP**
- Counts gap cycles, then goes to WAIT_RDY.

**DONE**
- Pulses `o_done` for one cycle, then returns to IDLE.

**Stop handling**
- `i_stop` sets a sticky stop flag in any non-IDLE state.
- A frame in progress is never truncated.
- `i_stop` in IDLE is ignored.

**Configuration changes**
- Changes to configuration inputs during a run have no effect until the next start.

## Timing
- All outputs are registered.
- Reset values: data 0, len 0, last 0, valid 0, busy 0, done 0, pkt_cnt 0. FSM resets to IDLE; `r_start_cnt` resets to 0.
- `i_start` at cycle N: WAIT_RDY at N+1. If ready is high at N+1, the first valid byte appears at N+2.
- Last byte at cycle L:
  - gap = 0: next valid no earlier than L+2.
  - gap = g: next valid no earlier than L+g+2.
  - In both cases at least g+1 idle cycles separate frames.
- `o_send_udp_len` holds the latched len while valid is high and is 0 when idle.
- Reset asserted mid-frame: all outputs drop to reset values immediately (asynchronous). No partial frame resumes, and auto-start re-arms.
- `i_start` and `i_stop` in the same cycle while IDLE: start wins and the stop is discarded.
- `i_stop` during the last byte: no further frame is sent; DONE follows.

## Test plan
- **Auto-start.** Reset release with defaults, i_len = 100, i_gap = 0, i_mode = 0, i_pkt_num = 2, ready tied high.
  - Required: first valid at cycle 102 after reset release.
  - Required: two frames of bytes 0..99; last on byte 99; len = 100; o_done pulse; o_pkt_cnt = 2.
- **PRBS and length clamping.**
  - Mode 1, len = 3: bytes FF, FE, FC.
  - len = 0: exactly one byte, with last = 1.
  - len = 2000: exactly 1472 bytes.
- **Sequence-tagged frames.** Mode 3, len = 6, i_pkt_num = 3.
  - Frame 2 payload: 00 01 02 03 04 05.
  - Frame 3 begins 00 02.
- **Gap and ready gating.** gap = 5, with ready low for 20 cycles after frame 1.
  - Required: valid stays low until one cycle after ready rises.
  - Required: no frame ever starts while ready is low.
- **Stop mid-frame.** i_pkt_num = 0 (unlimited); i_stop pulsed on byte 40 of frame 4 (len 100).
  - Required: frame 4 completes; o_pkt_cnt = 4; o_done pulses; no frame 5.
- **Reset during SEND.** Assert reset at byte 50.
  - Required: valid drops in the same cycle; all outputs take reset values; the next run restarts at byte 0.

Source files
------------

// File: rtl/udp_traffic_gen.sv
// udp_traffic_gen: run-time configurable UDP payload generator for the stack
// send interface. Supports incrementing, PRBS-8, constant and sequence-tagged
// payloads, inter-frame gaps, frame counts, auto-start and graceful stop.
module udp_traffic_gen #(
    parameter int unsigned P_MAX_LEN     = 1472,
    parameter bit          P_AUTO_START  = 1'b1,
    parameter int unsigned P_START_DELAY = 100,
    parameter logic [7:0]  P_PRBS_SEED   = 8'hFF,
    parameter logic [7:0]  P_CONST_BYTE  = 8'hA5
) (
    input  logic        w_user_clk,
    input  logic        w_user_rst,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic [1:0]  i_mode,
    input  logic [15:0] i_len,
    input  logic [15:0] i_gap,
    input  logic [31:0] i_pkt_num,
    input  logic        i_send_ready,
    output logic [7:0]  o_send_udp_data,
    output logic [15:0] o_send_udp_len,
    output logic        o_send_udp_last,
    output logic        o_send_udp_valid,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_pkt_cnt
);

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned BYTE_W = 8;

    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(P_MAX_LEN);
    localparam logic [CNT_W-1:0] START_DLY = CNT_W'(P_START_DELAY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    gap_q, gap_d;
    logic [LEN_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    pkt_num_q, pkt_num_d;
    logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]    r_start_cnt_q, r_start_cnt_d;
    logic                stop_q, stop_d;
    logic [BYTE_W-1:0]   lfsr_q, lfsr_d;

    logic [BYTE_W-1:0]   data_q, data_d;
    logic [LEN_W-1:0]    olen_q, olen_d;
    logic                last_q, last_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [LEN_W-1:0]    len_clamp;
    logic [BYTE_W-1:0]   lfsr_next;
    logic                auto_evt;
    logic                trigger;

    // Payload byte for a given pattern, byte index, LFSR state and frame tag.
    function automatic logic [BYTE_W-1:0] f_payload(
        input logic [1:0]        mode,
        input logic [LEN_W-1:0]  idx,
        input logic [BYTE_W-1:0] lfsr,
        input logic [15:0]       tag
    );
        case (mode)
            2'd0:    f_payload = idx[7:0];
            2'd1:    f_payload = lfsr;
            2'd2:    f_payload = P_CONST_BYTE;
            default: begin
                if (idx == LEN_W'(0))      f_payload = tag[15:8];
                else if (idx == LEN_W'(1)) f_payload = tag[7:0];
                else                       f_payload = idx[7:0];
            end
        endcase
    endfunction

    // Requested length clamped into [1, P_MAX_LEN].
    assign len_clamp = (i_len == LEN_W'(0)) ? LEN_W'(1) :
                       (i_len > MAX_LEN)    ? MAX_LEN   : i_len;

    // x^8+x^6+x^5+x^4+1, Fibonacci form, shifting left.
    assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    assign auto_evt = P_AUTO_START && (r_start_cnt_q == START_DLY);
    assign trigger  = i_start | auto_evt;

    // State, configuration and output registers.
    always_ff @(posedge w_user_clk or posedge w_user_rst) begin
        if (w_user_rst) begin
            state_q       <= S_IDLE;
            mode_q        <= 2'd0;
            len_q         <= '0;
            gap_q         <= '0;
            gap_cnt_q     <= '0;
            idx_q         <= '0;
            pkt_num_q     <= '0;
            pkt_cnt_q     <= '0;
            r_start_cnt_q <= '0;
            stop_q        <= 1'b0;
            lfsr_q        <= '0;
            data_q        <= '0;
            olen_q        <= '0;
            last_q        <= 1'b0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            len_q         <= len_d;
            gap_q         <= gap_d;
            gap_cnt_q     <= gap_cnt_d;
            idx_q         <= idx_d;
            pkt_num_q     <= pkt_num_d;
            pkt_cnt_q     <= pkt_cnt_d;
            r_start_cnt_q <= r_start_cnt_d;
            stop_q        <= stop_d;
            lfsr_q        <= lfsr_d;
            data_q        <= data_d;
            olen_q        <= olen_d;
            last_q        <= last_d;
            valid_q       <= valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Next-state logic; outputs are derived from the next state so they register with it.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        len_d         = len_q;
        gap_d         = gap_q;
        gap_cnt_d     = gap_cnt_q;
        idx_d         = idx_q;
        pkt_num_d     = pkt_num_q;
        pkt_cnt_d     = pkt_cnt_q;
        stop_d        = stop_q;
        lfsr_d        = lfsr_q;
        data_d        = '0;
        olen_d        = '0;
        last_d        = 1'b0;
        valid_d       = 1'b0;
        // Counter saturates one past the delay so the auto-start fires only once.
        r_start_cnt_d = (r_start_cnt_q <= START_DLY) ? r_start_cnt_q + CNT_W'(1) : r_start_cnt_q;

        if (state_q != S_IDLE && i_stop) stop_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    mode_d    = i_mode;
                    len_d     = len_clamp;
                    gap_d     = i_gap;
                    pkt_num_d = i_pkt_num;
                    pkt_cnt_d = '0;
                    stop_d    = 1'b0;
                    state_d   = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (stop_d) begin
                    state_d = S_DONE;
                end else if (i_send_ready) begin
                    idx_d   = '0;
                    lfsr_d  = P_PRBS_SEED;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (idx_q == len_q - LEN_W'(1)) begin
                    pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                    if (stop_d || (pkt_num_q != '0 && pkt_cnt_d == pkt_num_q)) begin
                        state_d = S_DONE;
                    end else if (gap_q != '0) begin
                        gap_cnt_d = LEN_W'(1);
                        state_d   = S_GAP;
                    end else begin
                        state_d = S_WAIT_RDY;
                    end
                end else begin
                    idx_d  = idx_q + LEN_W'(1);
                    lfsr_d = lfsr_next;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == gap_q) state_d = S_WAIT_RDY;
                else                    gap_cnt_d = gap_cnt_q + LEN_W'(1);
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_SEND) begin
            valid_d = 1'b1;
            last_d  = (idx_d == len_d - LEN_W'(1));
            olen_d  = len_d;
            data_d  = f_payload(mode_d, idx_d, lfsr_d, pkt_cnt_d[15:0]);
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign o_send_udp_data  = data_q;
    assign o_send_udp_len   = olen_q;
    assign o_send_udp_last  = last_q;
    assign o_send_udp_valid = valid_q;
    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_pkt_cnt        = pkt_cnt_q;

endmodule

// File: tb/tb_udp_traffic_gen.sv
// tb_udp_traffic_gen: randomized frame-level checks of udp_traffic_gen against
// a payload/length/count reference model derived from the pattern rules.
`timescale 1ns/1ps
module tb_udp_traffic_gen;

    localparam int unsigned MAX_LEN   = 1472;
    localparam int unsigned START_DLY = 100;
    localparam int          TMO       = 400;

    logic        w_user_clk = 1'b0;
    logic        w_user_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_stop = 1'b0;
    logic [1:0]  i_mode = 2'd0;
    logic [15:0] i_len = 16'd0;
    logic [15:0] i_gap = 16'd0;
    logic [31:0] i_pkt_num = 32'd0;
    logic        i_send_ready = 1'b1;
    logic [7:0]  o_send_udp_data;
    logic [15:0] o_send_udp_len;
    logic        o_send_udp_last;
    logic        o_send_udp_valid;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_pkt_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  prbs_ref [0:MAX_LEN+3];
    logic [7:0]  frm_data[$];
    logic [15:0] frm_lenv[$];
    int          frm_wait;
    bit          frm_ok;

    always #5 w_user_clk = ~w_user_clk;

    udp_traffic_gen #(
        .P_MAX_LEN    (MAX_LEN),
        .P_AUTO_START (1'b1),
        .P_START_DELAY(START_DLY),
        .P_PRBS_SEED  (8'hFF),
        .P_CONST_BYTE (8'hA5)
    ) dut (
        .w_user_clk      (w_user_clk),
        .w_user_rst      (w_user_rst),
        .i_start         (i_start),
        .i_stop          (i_stop),
        .i_mode          (i_mode),
        .i_len           (i_len),
        .i_gap           (i_gap),
        .i_pkt_num       (i_pkt_num),
        .i_send_ready    (i_send_ready),
        .o_send_udp_data (o_send_udp_data),
        .o_send_udp_len  (o_send_udp_len),
        .o_send_udp_last (o_send_udp_last),
        .o_send_udp_valid(o_send_udp_valid),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_pkt_cnt       (o_pkt_cnt)
    );

    // PRBS-8 reference: byte 0 is the seed, each later byte is the previous
    // value times x with the tap parity (bits 7,5,4,3) fed into bit 0.
    function automatic void build_prbs();
        int v = 8'hFF;
        for (int k = 0; k <= int'(MAX_LEN) + 3; k++) begin
            prbs_ref[k] = 8'(v);
            v = ((v * 2) % 256) + ($countones(v & 8'hB8) % 2);
        end
    endfunction

    function automatic int clamp_len(input int len);
        if (len == 0) return 1;
        if (len > int'(MAX_LEN)) return int'(MAX_LEN);
        return len;
    endfunction

    function automatic logic [7:0] exp_byte(input int mode, input int k, input int tag);
        case (mode)
            0: return 8'(k);
            1: return prbs_ref[k];
            2: return 8'hA5;
            default: begin
                if (k == 0)      return 8'((tag / 256) % 256);
                else if (k == 1) return 8'(tag % 256);
                else             return 8'(k);
            end
        endcase
    endfunction

    // Number of payload bytes or len-field values in the captured frame that differ from the model.
    function automatic int frame_errs(input int mode, input int len, input int tag);
        int e = 0;
        for (int k = 0; k < frm_data.size(); k++) begin
            if (frm_data[k] !== exp_byte(mode, k, tag)) e++;
            if (frm_lenv[k] !== 16'(len)) e++;
        end
        return e;
    endfunction

    // Captures one frame starting at the current falling edge; can raise i_stop on
    // byte stop_at (left high if that is the last byte) or return early at abort_at.
    task automatic get_frame(input int max_wait, input int stop_at, input int abort_at);
        int idx = 0;
        frm_data.delete();
        frm_lenv.delete();
        frm_wait = 0;
        frm_ok   = 1'b0;
        while (o_send_udp_valid !== 1'b1 && frm_wait < max_wait) begin
            @(negedge w_user_clk);
            frm_wait++;
        end
        if (o_send_udp_valid !== 1'b1) return;
        forever begin
            frm_data.push_back(o_send_udp_data);
            frm_lenv.push_back(o_send_udp_len);
            if (idx == stop_at) i_stop = 1'b1;
            if (idx == abort_at || o_send_udp_last === 1'b1) begin
                frm_ok = 1'b1;
                return;
            end
            @(negedge w_user_clk);
            i_stop = 1'b0;
            idx++;
            if (o_send_udp_valid !== 1'b1 || idx >= int'(MAX_LEN) + 2) return;
        end
    endtask

    task automatic wait_done(input int max_wait, output bit seen);
        int w = 0;
        seen = 1'b0;
        while (w <= max_wait) begin
            if (o_done === 1'b1) begin
                seen = 1'b1;
                return;
            end
            @(negedge w_user_clk);
            w++;
        end
    endtask

    // Pulses i_start with a configuration, then scrambles the configuration inputs.
    task automatic run_start(input int mode, input int len, input int gap, input int num, input bit with_stop);
        repeat (2) @(negedge w_user_clk);
        i_mode    = 2'(mode);
        i_len     = 16'(len);
        i_gap     = 16'(gap);
        i_pkt_num = 32'(num);
        i_start   = 1'b1;
        i_stop    = with_stop;
        @(negedge w_user_clk);
        i_start   = 1'b0;
        i_stop    = 1'b0;
        i_mode    = 2'($urandom);
        i_len     = 16'($urandom);
        i_gap     = 16'($urandom);
        i_pkt_num = 32'($urandom);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge w_user_clk);
        n_checks++;
        if ({o_send_udp_data, o_send_udp_len, o_send_udp_last, o_send_udp_valid, o_busy, o_done, o_pkt_cnt} !== 60'd0)
            $display("FAIL reset_outputs: got data=%h len=%0d last=%b valid=%b busy=%b done=%b cnt=%0d, required all 0",
                     o_send_udp_data, o_send_udp_len, o_send_udp_last, o_send_udp_valid, o_busy, o_done, o_pkt_cnt);
        else n_pass++;
    endtask

    task automatic test_auto_start();
        int  first = -1;
        bit  seen;
        i_len = 16'd100; i_gap = 16'd0; i_mode = 2'd0; i_pkt_num = 32'd2; i_send_ready = 1'b1;
        w_user_rst = 1'b0;
        for (int k = 1; k <= TMO; k++) begin
            @(negedge w_user_clk);
            if (o_send_udp_valid === 1'b1) begin
                first = k;
                break;
            end
        end
        n_checks++;
        if (first != 102) $display("FAIL auto_first_valid: got cycle %0d, required 102", first);
        else n_pass++;
        n_checks++;
        if (o_busy !== 1'b1) $display("FAIL auto_busy: got %b, required 1", o_busy);
        else n_pass++;
        for (int f = 0; f < 2; f++) begin
            if (f == 1) @(negedge w_user_clk);
            get_frame(TMO, -1, -1);
            n_checks++;
            if (!frm_ok || frm_data.size() != 100)
                $display("FAIL auto_frame%0d_size: got %0d bytes (ok=%b), required 100", f + 1, frm_data.size(), frm_ok);
            else n_pass++;
            n_checks++;
            if (frame_errs(0, 100, f) != 0)
                $display("FAIL auto_frame%0d_data: got %0d errors, required 0", f + 1, frame_errs(0, 100, f));
            else n_pass++;
            if (f == 1) begin
                n_checks++;
                if (frm_wait != 1) $display("FAIL auto_gap0_idle: got %0d idle cycles, required 1", frm_wait);
                else n_pass++;
            end
        end
        wait_done(20, seen);
        n_checks++;
        if (!seen || o_pkt_cnt !== 32'd2)
            $display("FAIL auto_done_cnt: got done=%b cnt=%0d, required done=1 cnt=2", seen, o_pkt_cnt);
        else n_pass++;
        @(negedge w_user_clk);
        n_checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0)
            $display("FAIL auto_done_pulse: got done=%b busy=%b, required 0 0", o_done, o_busy);
        else n_pass++;
    endtask

    task automatic test_prbs_clamp();
        int  lens[7];
        int  modes[7];
        int  l;
        bit  seen;
        lens[0] = 3;    modes[0] = 1;
        lens[1] = 0;    modes[1] = int'($urandom_range(0, 3));
        lens[2] = 2000; modes[2] = 1;
        for (int r = 3; r < 7; r++) begin
            lens[r]  = int'($urandom_range(1, 300));
            modes[r] = int'($urandom_range(0, 3));
        end
        for (int r = 0; r < 7; r++) begin
            l = clamp_len(lens[r]);
            run_start(modes[r], lens[r], int'($urandom_range(0, 3)), 1, 1'b0);
            get_frame(TMO, -1, -1);
            n_checks++;
            if (!frm_ok || frm_data.size() != l)
                $display("FAIL clamp_size_len%0d: got %0d bytes (ok=%b), required %0d", lens[r], frm_data.size(), frm_ok, l);
            else n_pass++;
            n_checks++;
            if (frame_errs(modes[r], l, 0) != 0)
                $display("FAIL payload_mode%0d_len%0d: got %0d errors, required 0", modes[r], l, frame_errs(modes[r], l, 0));
            else n_pass++;
            if (r == 0) begin
                n_checks++;
                if (frm_data.size() != 3 || {frm_data[0], frm_data[1], frm_data[2]} !== 24'hFFFEFC)
                    $display("FAIL prbs_first3: got %0d bytes, required FF FE FC", frm_data.size());
                else n_pass++;
            end
            wait_done(20, seen);
            n_checks++;
            if (!seen || o_pkt_cnt !== 32'd1)
                $display("FAIL single_done_cnt: got done=%b cnt=%0d, required done=1 cnt=1", seen, o_pkt_cnt);
            else n_pass++;
        end
    endtask

    task automatic test_seq_tag();
        bit seen;
        run_start(3, 6, 0, 3, 1'b0);
        for (int f = 0; f < 3; f++) begin
            if (f > 0) @(negedge w_user_clk);
            get_frame(TMO, -1, -1);
            n_checks++;
            if (!frm_ok || frm_data.size() != 6 || frame_errs(3, 6, f) != 0)
                $display("FAIL seq_frame%0d: got %0d bytes with %0d errors, required 6 bytes 0 errors",
                         f + 1, frm_data.size(), frame_errs(3, 6, f));
            else n_pass++;
        end
        n_checks++;
        if (frm_data.size() < 2 || frm_data[0] !== 8'h00 || frm_data[1] !== 8'h02)
            $display("FAIL seq_frame3_tag: got size %0d, required frame starting 00 02", frm_data.size());
        else n_pass++;
        wait_done(20, seen);
        n_checks++;
        if (!seen || o_pkt_cnt !== 32'd3)
            $display("FAIL seq_done_cnt: got done=%b cnt=%0d, required done=1 cnt=3", seen, o_pkt_cnt);
        else n_pass++;
    endtask

    task automatic test_gap_ready();
        int g    = int'($urandom_range(1, 8));
        int len  = int'($urandom_range(1, 40));
        int mode = int'($urandom_range(0, 3));
        int bad  = 0;
        bit seen;
        run_start(mode, len, g, 2, 1'b0);
        get_frame(TMO, -1, -1);
        @(negedge w_user_clk);
        get_frame(TMO, -1, -1);
        n_checks++;
        if (!frm_ok || frm_wait != g + 1)
            $display("FAIL gap_idle: got %0d idle cycles, required %0d", frm_wait, g + 1);
        else n_pass++;
        n_checks++;
        if (frm_data.size() != len || frame_errs(mode, len, 1) != 0)
            $display("FAIL gap_frame2: got %0d bytes %0d errors, required %0d bytes", frm_data.size(), frame_errs(mode, len, 1), len);
        else n_pass++;
        wait_done(20, seen);

        len = int'($urandom_range(1, 40));
        run_start(mode, len, 5, 2, 1'b0);
        get_frame(TMO, -1, -1);
        i_send_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge w_user_clk);
            if (o_send_udp_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL ready_low_hold: got %0d valid cycles while not ready, required 0", bad);
        else n_pass++;
        i_send_ready = 1'b1;
        @(negedge w_user_clk);
        n_checks++;
        if (o_send_udp_valid !== 1'b1) $display("FAIL valid_after_ready: got %b, required 1", o_send_udp_valid);
        else n_pass++;
        get_frame(TMO, -1, -1);
        n_checks++;
        if (frm_data.size() != len || frame_errs(mode, len, 1) != 0)
            $display("FAIL ready_frame2: got %0d bytes %0d errors, required %0d bytes", frm_data.size(), frame_errs(mode, len, 1), len);
        else n_pass++;
        wait_done(20, seen);
        n_checks++;
        if (!seen || o_pkt_cnt !== 32'd2)
            $display("FAIL ready_done_cnt: got done=%b cnt=%0d, required done=1 cnt=2", seen, o_pkt_cnt);
        else n_pass++;
    endtask

    task automatic test_stop();
        int mode = int'($urandom_range(0, 3));
        int len;
        int extra = 0;
        bit seen;
        run_start(mode, 100, int'($urandom_range(0, 3)), 0, 1'b0);
        for (int f = 0; f < 4; f++) begin
            if (f > 0) @(negedge w_user_clk);
            get_frame(TMO, (f == 3) ? 40 : -1, -1);
        end
        n_checks++;
        if (!frm_ok || frm_data.size() != 100 || frame_errs(mode, 100, 3) != 0)
            $display("FAIL stop_frame4: got %0d bytes %0d errors, required 100 bytes", frm_data.size(), frame_errs(mode, 100, 3));
        else n_pass++;
        wait_done(20, seen);
        n_checks++;
        if (!seen || o_pkt_cnt !== 32'd4)
            $display("FAIL stop_done_cnt: got done=%b cnt=%0d, required done=1 cnt=4", seen, o_pkt_cnt);
        else n_pass++;
        for (int c = 0; c < 150; c++) begin
            @(negedge w_user_clk);
            if (o_send_udp_valid === 1'b1) extra++;
        end
        n_checks++;
        if (extra != 0) $display("FAIL stop_no_frame5: got %0d valid cycles, required 0", extra);
        else n_pass++;

        len = int'($urandom_range(2, 30));
        run_start(mode, len, 0, 0, 1'b0);
        get_frame(TMO, len - 1, -1);
        @(negedge w_user_clk);
        i_stop = 1'b0;
        wait_done(20, seen);
        n_checks++;
        if (!seen || o_pkt_cnt !== 32'd1)
            $display("FAIL stop_last_byte: got done=%b cnt=%0d, required done=1 cnt=1", seen, o_pkt_cnt);
        else n_pass++;

        @(negedge w_user_clk);
        i_stop = 1'b1;
        @(negedge w_user_clk);
        i_stop = 1'b0;
        len = int'($urandom_range(1, 20));
        run_start(mode, len, 0, 2, 1'b1);
        get_frame(TMO, -1, -1);
        @(negedge w_user_clk);
        get_frame(TMO, -1, -1);
        wait_done(20, seen);
        n_checks++;
        if (!seen || o_pkt_cnt !== 32'd2)
            $display("FAIL start_beats_stop: got done=%b cnt=%0d, required done=1 cnt=2", seen, o_pkt_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int len;
        int first = -1;
        run_start(0, 100, 0, 1, 1'b0);
        get_frame(TMO, -1, 50);
        w_user_rst = 1'b1;
        #1;
        n_checks++;
        if ({o_send_udp_data, o_send_udp_len, o_send_udp_last, o_send_udp_valid, o_busy, o_done, o_pkt_cnt} !== 60'd0)
            $display("FAIL reset_mid_outputs: got valid=%b data=%h len=%0d busy=%b, required all 0",
                     o_send_udp_valid, o_send_udp_data, o_send_udp_len, o_busy);
        else n_pass++;
        len = int'($urandom_range(10, 60));
        i_mode = 2'd0; i_len = 16'(len); i_gap = 16'd0; i_pkt_num = 32'd1;
        repeat (3) @(negedge w_user_clk);
        w_user_rst = 1'b0;
        for (int k = 1; k <= TMO; k++) begin
            @(negedge w_user_clk);
            if (o_send_udp_valid === 1'b1) begin
                first = k;
                break;
            end
        end
        n_checks++;
        if (first != 102) $display("FAIL rearm_first_valid: got cycle %0d, required 102", first);
        else n_pass++;
        get_frame(TMO, -1, -1);
        n_checks++;
        if (!frm_ok || frm_data.size() != len || frame_errs(0, len, 0) != 0)
            $display("FAIL rearm_frame: got %0d bytes %0d errors, required %0d bytes from 0", frm_data.size(), frame_errs(0, len, 0), len);
        else n_pass++;
    endtask

    initial begin
        build_prbs();
        test_reset();
        test_auto_start();
        test_prbs_clamp();
        test_seq_tag();
        test_gap_ready();
        test_stop();
        test_reset_mid();
        repeat (5) @(negedge w_user_clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
